crono_countdown: RTL and testbench

Countdown engine for the chronometer mode. It snapshots the user-set hour/minute/second values from the chronometer setting counters and decrements them once per 1 Hz tick. On reaching 00:00:00 it raises an alarm and holds it until acknowledged or timed out. Outputs feed the display mux and the alarm/buzzer logic.

---
 rtl/crono_countdown.sv | 155 +++++++++++++++
 tb/tb_crono_countdown.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/crono_countdown.sv
// Chronometer countdown engine: loads a clamped hh:mm:ss value and decrements it
// on each 1 Hz tick. At 00:00:00 it raises an alarm, held until ack or timeout.
module crono_countdown #(
  parameter int HR_MAX        = 23,
  parameter int ALARM_TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load_en,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       ack,
  input  logic [4:0] set_hr,
  input  logic [5:0] set_min,
  input  logic [5:0] set_seg,
  output logic [4:0] cnt_hr,
  output logic [5:0] cnt_min,
  output logic [5:0] cnt_seg,
  output logic       running,
  output logic       alarm,
  output logic       done_pulse
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

  localparam int TW = (ALARM_TIMEOUT > 1) ? $clog2(ALARM_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((ALARM_TIMEOUT > 0) ? ALARM_TIMEOUT - 1 : 0);

  state_t        state_q;
  logic [4:0]    hr_q;
  logic [5:0]    min_q, seg_q;
  logic          running_q, alarm_q, done_q;
  logic [TW-1:0] to_q;

  logic [4:0]    ld_hr_d, dec_hr_d;
  logic [5:0]    ld_min_d, ld_seg_d, dec_min_d, dec_seg_d;
  logic          cnt_zero, dec_zero;

  // Clamp the setter values so a transient 60 (or an over-range hour) never lands in the count.
  always_comb begin
    ld_hr_d  = (set_hr > 5'(HR_MAX)) ? 5'(HR_MAX) : set_hr;
    ld_min_d = (set_min > 6'd59) ? 6'd59 : set_min;
    ld_seg_d = (set_seg > 6'd59) ? 6'd59 : set_seg;
  end

  // Borrow chain; a zero count stays zero rather than wrapping.
  always_comb begin
    dec_hr_d  = hr_q;
    dec_min_d = min_q;
    dec_seg_d = seg_q;
    if (seg_q != 6'd0) begin
      dec_seg_d = seg_q - 6'd1;
    end else if (min_q != 6'd0) begin
      dec_min_d = min_q - 6'd1;
      dec_seg_d = 6'd59;
    end else if (hr_q != 5'd0) begin
      dec_hr_d  = hr_q - 5'd1;
      dec_min_d = 6'd59;
      dec_seg_d = 6'd59;
    end
  end

  assign cnt_zero = (hr_q == 5'd0) && (min_q == 6'd0) && (seg_q == 6'd0);
  assign dec_zero = (dec_hr_d == 5'd0) && (dec_min_d == 6'd0) && (dec_seg_d == 6'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hr_q      <= '0;
      min_q     <= '0;
      seg_q     <= '0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
      done_q    <= 1'b0;
      to_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        state_q   <= IDLE;
        hr_q      <= '0;
        min_q     <= '0;
        seg_q     <= '0;
        running_q <= 1'b0;
        alarm_q   <= 1'b0;
        to_q      <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (load_en) begin
              hr_q  <= ld_hr_d;
              min_q <= ld_min_d;
              seg_q <= ld_seg_d;
            end else if (start && !cnt_zero) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
          RUN: begin
            if (stop) begin
              state_q   <= PAUSE;
              running_q <= 1'b0;
            end else if (tick) begin
              hr_q  <= dec_hr_d;
              min_q <= dec_min_d;
              seg_q <= dec_seg_d;
              if (dec_zero) begin
                state_q   <= ALARM;
                running_q <= 1'b0;
                alarm_q   <= 1'b1;
                done_q    <= 1'b1;
                to_q      <= '0;
              end
            end
          end
          PAUSE: begin
            if (start && !stop) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
          ALARM: begin
            if (ack) begin
              state_q <= IDLE;
              alarm_q <= 1'b0;
              to_q    <= '0;
            end else if (ALARM_TIMEOUT != 0 && tick) begin
              if (to_q == TO_LAST) begin
                state_q <= IDLE;
                alarm_q <= 1'b0;
                to_q    <= '0;
              end else begin
                to_q <= to_q + 1'b1;
              end
            end
          end
          default: begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cnt_hr     = hr_q;
  assign cnt_min    = min_q;
  assign cnt_seg    = seg_q;
  assign running    = running_q;
  assign alarm      = alarm_q;
  assign done_pulse = done_q;

endmodule

// File: tb/tb_crono_countdown.sv
// Bench for crono_countdown: a vector table plus hand-written countdown, alarm
// timeout/ack and reset/clear sequences, all checked through an expectation queue.
module tb_crono_countdown;

  logic       clk = 1'b0;
  logic       rst, tick, load_en, start, stop, clear, ack;
  logic [4:0] set_hr, cnt_hr;
  logic [5:0] set_min, set_seg, cnt_min, cnt_seg;
  logic       running, alarm, done_pulse;

  always #5 clk = ~clk;

  crono_countdown #(.HR_MAX(23), .ALARM_TIMEOUT(3)) dut (
    .clk(clk), .rst(rst), .tick(tick), .load_en(load_en), .start(start),
    .stop(stop), .clear(clear), .ack(ack), .set_hr(set_hr), .set_min(set_min),
    .set_seg(set_seg), .cnt_hr(cnt_hr), .cnt_min(cnt_min), .cnt_seg(cnt_seg),
    .running(running), .alarm(alarm), .done_pulse(done_pulse)
  );

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       r;
    logic       a;
    logic       d;
  } exp_t;

  typedef struct {
    logic [6:0] ctl;   // {rst, tick, load_en, start, stop, clear, ack}
    logic [4:0] sh;
    logic [5:0] sm;
    logic [5:0] ss;
    exp_t       e;
  } vec_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  vec_t tbl[21];

  function automatic vec_t mk(input logic [6:0] ctl, input int sh, input int sm, input int ss,
                              input int eh, input int em, input int es,
                              input logic er, input logic ea, input logic ed);
    vec_t v;
    v.ctl = ctl;
    v.sh = 5'(sh); v.sm = 6'(sm); v.ss = 6'(ss);
    v.e.h = 5'(eh); v.e.m = 6'(em); v.e.s = 6'(es);
    v.e.r = er; v.e.a = ea; v.e.d = ed;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
  task automatic apply(input vec_t v, input string name);
    exp_t got, want;
    @(negedge clk);
    {rst, tick, load_en, start, stop, clear, ack} = v.ctl;
    set_hr = v.sh; set_min = v.sm; set_seg = v.ss;
    exp_q.push_back(v.e);
    @(posedge clk);
    #1;
    got  = '{h: cnt_hr, m: cnt_min, s: cnt_seg, r: running, a: alarm, d: done_pulse};
    want = exp_q.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %02d:%02d:%02d run=%b alm=%b done=%b, want %02d:%02d:%02d run=%b alm=%b done=%b",
               name, got.h, got.m, got.s, got.r, got.a, got.d,
               want.h, want.m, want.s, want.r, want.a, want.d);
    end else begin
      $display("ok   %s: %02d:%02d:%02d run=%b alm=%b done=%b",
               name, got.h, got.m, got.s, got.r, got.a, got.d);
    end
  endtask

  // ctl bit masks
  localparam logic [6:0] C_RST = 7'b1000000, C_TCK = 7'b0100000, C_LD  = 7'b0010000,
                         C_ST  = 7'b0001000, C_SP  = 7'b0000100, C_CLR = 7'b0000010,
                         C_ACK = 7'b0000001, C_NO  = 7'b0000000;

  initial begin
    int r;
    tbl[0]  = mk(C_LD,               1, 0, 0,    1, 0, 0,    0, 0, 0);
    tbl[1]  = mk(C_ST,               0, 0, 0,    1, 0, 0,    1, 0, 0);
    tbl[2]  = mk(C_TCK,              0, 0, 0,    0, 59, 59,  1, 0, 0);
    tbl[3]  = mk(C_LD | C_ST,        5, 5, 5,    0, 59, 59,  1, 0, 0);
    tbl[4]  = mk(C_SP | C_TCK,       0, 0, 0,    0, 59, 59,  0, 0, 0);
    tbl[5]  = mk(C_TCK,              0, 0, 0,    0, 59, 59,  0, 0, 0);
    tbl[6]  = mk(C_ST | C_SP,        0, 0, 0,    0, 59, 59,  0, 0, 0);
    tbl[7]  = mk(C_ST,               0, 0, 0,    0, 59, 59,  1, 0, 0);
    tbl[8]  = mk(C_CLR | C_ST,       0, 0, 0,    0, 0, 0,    0, 0, 0);
    tbl[9]  = mk(C_LD,               30, 60, 60, 23, 59, 59, 0, 0, 0);
    tbl[10] = mk(C_LD,               31, 63, 0,  23, 59, 0,  0, 0, 0);
    tbl[11] = mk(C_LD | C_ST,        0, 0, 10,   0, 0, 10,   0, 0, 0);
    tbl[12] = mk(C_TCK,              0, 0, 0,    0, 0, 10,   0, 0, 0);
    tbl[13] = mk(C_ST,               0, 0, 0,    0, 0, 10,   1, 0, 0);
    tbl[14] = mk(C_SP | C_TCK,       0, 0, 0,    0, 0, 10,   0, 0, 0);
    tbl[15] = mk(C_TCK,              0, 0, 0,    0, 0, 10,   0, 0, 0);
    tbl[16] = mk(C_ST,               0, 0, 0,    0, 0, 10,   1, 0, 0);
    tbl[17] = mk(C_TCK,              0, 0, 0,    0, 0, 9,    1, 0, 0);
    tbl[18] = mk(C_CLR,              0, 0, 0,    0, 0, 0,    0, 0, 0);
    tbl[19] = mk(C_LD,               0, 0, 0,    0, 0, 0,    0, 0, 0);
    tbl[20] = mk(C_ST,               0, 0, 0,    0, 0, 0,    0, 0, 0);

    {rst, tick, load_en, start, stop, clear, ack} = C_RST;
    set_hr = '0; set_min = '0; set_seg = '0;
    apply(mk(C_RST, 0, 0, 0, 0, 0, 0, 0, 0, 0), "reset");
    apply(mk(C_RST | C_LD, 9, 9, 9, 0, 0, 0, 0, 0, 0), "reset_over_load");

    for (int i = 0; i < 21; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // 00:01:02 counts down over 62 ticks into ALARM
    apply(mk(C_LD, 0, 1, 2, 0, 1, 2, 0, 0, 0), "cd_load");
    apply(mk(C_ST, 0, 0, 0, 0, 1, 2, 1, 0, 0), "cd_start");
    for (int k = 1; k <= 62; k++) begin
      r = 62 - k;
      apply(mk(C_TCK, 0, 0, 0, 0, r / 60, r % 60, r != 0, r == 0, r == 0),
            $sformatf("cd_tick%0d", k));
    end
    apply(mk(C_NO, 0, 0, 0, 0, 0, 0, 0, 1, 0), "alarm_hold");
    apply(mk(C_LD | C_ST, 5, 5, 5, 0, 0, 0, 0, 1, 0), "alarm_ignores_load");
    apply(mk(C_TCK, 0, 0, 0, 0, 0, 0, 0, 1, 0), "to_tick1");
    apply(mk(C_TCK, 0, 0, 0, 0, 0, 0, 0, 1, 0), "to_tick2");
    apply(mk(C_TCK, 0, 0, 0, 0, 0, 0, 0, 0, 0), "to_tick3");
    apply(mk(C_TCK, 0, 0, 0, 0, 0, 0, 0, 0, 0), "idle_after_to");

    // Second alarm, acknowledged after one tick; timeout counter must restart
    apply(mk(C_LD, 0, 0, 1, 0, 0, 1, 0, 0, 0), "ack_load");
    apply(mk(C_ST, 0, 0, 0, 0, 0, 1, 1, 0, 0), "ack_start");
    apply(mk(C_TCK, 0, 0, 0, 0, 0, 0, 0, 1, 1), "ack_enter");
    apply(mk(C_TCK, 0, 0, 0, 0, 0, 0, 0, 1, 0), "ack_tick1");
    apply(mk(C_ACK, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ack");
    apply(mk(C_ST, 0, 0, 0, 0, 0, 0, 0, 0, 0), "idle_zero_start");

    // Reset and clear mid-countdown
    apply(mk(C_LD, 0, 0, 5, 0, 0, 5, 0, 0, 0), "rst_load");
    apply(mk(C_ST, 0, 0, 0, 0, 0, 5, 1, 0, 0), "rst_start");
    apply(mk(C_RST | C_TCK, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_mid");
    apply(mk(C_TCK, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_idle");
    apply(mk(C_LD, 0, 0, 5, 0, 0, 5, 0, 0, 0), "clr_load");
    apply(mk(C_ST, 0, 0, 0, 0, 0, 5, 1, 0, 0), "clr_start");
    apply(mk(C_CLR | C_TCK | C_ST, 0, 0, 0, 0, 0, 0, 0, 0, 0), "clr_mid");
    apply(mk(C_TCK, 0, 0, 0, 0, 0, 0, 0, 0, 0), "clr_idle");

    // Clear in ALARM drops the alarm
    apply(mk(C_LD, 0, 0, 1, 0, 0, 1, 0, 0, 0), "clra_load");
    apply(mk(C_ST, 0, 0, 0, 0, 0, 1, 1, 0, 0), "clra_start");
    apply(mk(C_TCK, 0, 0, 0, 0, 0, 0, 0, 1, 1), "clra_enter");
    apply(mk(C_CLR | C_ACK, 0, 0, 0, 0, 0, 0, 0, 0, 0), "clra_clear");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
